// File: rtl/vec_shift_scale.sv
// vec_shift_scale: two-stage valid/ready pipeline that scales every vector element by 2^-shamt,
// with per-vector signed/unsigned mode and optional round-half-up.
module vec_shift_scale #(
  parameter int IWIDTH  = 10,
  parameter int NINPUTS = 8,
  parameter int SHWIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IWIDTH-1:0]  data [NINPUTS],
  input  logic [SHWIDTH-1:0] shamt,
  input  logic               signed_mode,
  input  logic               round_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IWIDTH-1:0]  out [NINPUTS]
);

  logic               s1_valid_q, s1_valid_d;
  logic [IWIDTH-1:0]  s1_data_q [NINPUTS];
  logic [SHWIDTH-1:0] s1_shamt_q;
  logic               s1_signed_q;
  logic               s1_round_q;

  logic               s2_valid_q, s2_valid_d;
  logic [IWIDTH-1:0]  s2_data_q [NINPUTS];
  logic [IWIDTH-1:0]  s2_data_d [NINPUTS];

  logic               adv2;

  // One extra bit of headroom keeps the rounding bias from overflowing in either mode.
  function automatic logic [IWIDTH-1:0] scale_elem(
    input logic [IWIDTH-1:0]  x,
    input logic [SHWIDTH-1:0] sh,
    input logic               sgn,
    input logic               rnd
  );
    logic        [IWIDTH:0] ext;
    logic        [IWIDTH:0] bias;
    logic        [IWIDTH:0] res;
    logic signed [IWIDTH:0] sres;
    ext  = {sgn & x[IWIDTH-1], x};
    bias = '0;
    sres = '0;
    if (int'(sh) >= IWIDTH) begin
      res = {(IWIDTH+1){ext[IWIDTH]}};
    end else begin
      if (rnd && (sh != '0)) bias = (IWIDTH+1)'(1) << (sh - 1'b1);
      ext = ext + bias;
      if (sgn) begin
        sres = $signed(ext) >>> sh;
        res  = sres;
      end else begin
        res = ext >> sh;
      end
    end
    return res[IWIDTH-1:0];
  endfunction

  always_comb begin
    adv2       = !s2_valid_q || out_ready;
    in_ready   = !rst && (!s1_valid_q || adv2);
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
    for (int i = 0; i < NINPUTS; i++) begin
      s2_data_d[i] = scale_elem(s1_data_q[i], s1_shamt_q, s1_signed_q, s1_round_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Stage 1: capture operands on an input transfer
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      for (int i = 0; i < NINPUTS; i++) s1_data_q[i] <= data[i];
      s1_shamt_q  <= shamt;
      s1_signed_q <= signed_mode;
      s1_round_q  <= round_en;
    end
  end

  // Stage 2: result register, drives the output port directly
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NINPUTS; i++) s2_data_q[i] <= '0;
    end else if (adv2 && s1_valid_q) begin
      for (int i = 0; i < NINPUTS; i++) s2_data_q[i] <= s2_data_d[i];
    end
  end

  assign out_valid = s2_valid_q;

  always_comb begin
    for (int i = 0; i < NINPUTS; i++) out[i] = s2_data_q[i];
  end

endmodule

// File: tb/tb_vec_shift_scale.sv
// Scoreboard bench for vec_shift_scale: directed vectors plus streaming, backpressure and mid-stream reset.
module tb_vec_shift_scale;
  localparam int IW = 10;
  localparam int NI = 8;
  localparam int SW = 4;

  typedef logic [IW-1:0] vec_t [NI];
  typedef struct {
    vec_t v;
    int   cyc;
    bit   lat;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  vec_t          data;
  logic [SW-1:0] shamt;
  logic          signed_mode;
  logic          round_en;
  logic          out_valid;
  logic          out_ready;
  vec_t          out;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt    = 0;
  int   cyc    = 0;
  int   bp_mode = 0;

  vec_shift_scale #(.IWIDTH(IW), .NINPUTS(NI), .SHWIDTH(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data(data),
    .shamt(shamt), .signed_mode(signed_mode), .round_en(round_en),
    .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // out_ready: 0 = always high, 1 = 30% duty random, 2 = held low
  initial out_ready = 1'b1;
  always @(posedge clk) begin
    #2;
    if (bp_mode == 1)      out_ready = ($urandom_range(0, 99) < 30);
    else if (bp_mode == 2) out_ready = 1'b0;
    else                   out_ready = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk_vec(input string nm, input vec_t act, input vec_t req);
    int bad;
    bad = -1;
    for (int i = 0; i < NI; i++) if (bad < 0 && act[i] !== req[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s elem %0d actual=%0h required=%0h", nm, bad, act[bad], req[bad]);
    end
  endtask

  function automatic vec_t iv(input int a [NI]);
    vec_t r;
    for (int i = 0; i < NI; i++) r[i] = a[i][IW-1:0];
    return r;
  endfunction

  // Reference scaling: floor division on integers, independent of bit tricks
  function automatic logic [IW-1:0] model(input logic [IW-1:0] x, input int sh, input bit sg, input bit rn);
    int v, d, r;
    v = sg ? int'($signed(x)) : int'(x);
    if (sh >= IW) begin
      r = (v < 0) ? -1 : 0;
    end else begin
      d = 1 << sh;
      if (rn && sh > 0) v = v + d / 2;
      r = v / d;
      if ((v % d) != 0 && v < 0) r = r - 1;
    end
    return r[IW-1:0];
  endfunction

  // Called at posedge+1; returns at posedge+1 after the transfer edge
  task automatic send(input vec_t d, input int sh, input bit sg, input bit rn, input vec_t e, input bit lat);
    int   n;
    exp_t it;
    n = 0;
    data = d; shamt = sh[SW-1:0]; signed_mode = sg; round_en = rn; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=in_ready_low required=accept_within_1000");
      @(posedge clk); #1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    it.v = e; it.cyc = cyc; it.lat = lat;
    q.push_back(it);
    cnt++;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (q.size() != 0 && n < 2000);
    #1;
    chk("drain_pending", q.size(), 0);
  endtask

  // Monitor: pops expected vectors on output transfers, checks stalls and in_ready
  initial begin : monitor
    bit   prev_stall;
    vec_t prev_out;
    exp_t e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("in_ready_rst", in_ready, 0);
        prev_stall = 1'b0;
      end else begin
        chk("in_ready", in_ready, !(cnt == 2 && !out_ready));
        if (prev_stall) begin
          chk("stall_valid", out_valid, 1);
          chk_vec("stall_out", out, prev_out);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out actual=%0h required=no_output", out[0]);
          end else begin
            e = q.pop_front();
            chk_vec("out_data", out, e.v);
            if (e.lat) chk("latency", cyc, e.cyc + 1);
          end
          cnt--;
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = out;
      end
    end
  end

  initial begin : driver
    vec_t d, e, z;
    int   sh;
    bit   sg, rn;
    for (int i = 0; i < NI; i++) z[i] = '0;
    rst = 1'b1; in_valid = 1'b0; data = z; shamt = '0; signed_mode = 1'b0; round_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk_vec("rst_out", out, z);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Legacy divide-by-2
    send(iv('{0, 1, 2, 3, 511, 512, 1022, 1023}), 1, 0, 0,
         iv('{0, 0, 1, 1, 255, 256, 511, 511}), 1);
    // Signed, rounded and truncated
    send(iv('{-3, -1, 3, 5, -512, 511, 0, -4}), 1, 1, 1,
         iv('{-1, 0, 2, 3, -256, 256, 0, -2}), 1);
    send(iv('{-3, -1, 3, 5, -512, 511, 0, -4}), 1, 1, 0,
         iv('{-2, -1, 1, 2, -256, 255, 0, -2}), 1);
    // shamt boundaries, rounding requested where it must be ignored
    send(iv('{1023, 0, 1, 512, 7, 1023, 1023, 1023}), 0, 0, 1,
         iv('{1023, 0, 1, 512, 7, 1023, 1023, 1023}), 1);
    send(iv('{1023, 0, 1, 512, 7, 1023, 1023, 1023}), 10, 0, 1, z, 1);
    send(iv('{1023, 0, 1, 512, 7, 1023, 1023, 1023}), 15, 0, 0, z, 1);
    send(iv('{-5, 5, -1, 0, 511, -512, 1, -2}), 12, 1, 1,
         iv('{-1, 0, -1, 0, 0, -1, 0, -1}), 1);
    // Unsigned round at shamt just below width
    send(iv('{1023, 511, 512, 0, 256, 767, 768, 1}), 9, 0, 1,
         iv('{2, 1, 1, 0, 1, 1, 2, 0}), 1);
    drain();

    // Streaming: 16 back-to-back vectors, distinct shamt each
    for (int i = 0; i < 16; i++) begin
      sg = i[0]; rn = i[1];
      for (int j = 0; j < NI; j++) begin
        d[j] = IW'(i * 37 + j * 101 + 3);
        e[j] = model(d[j], i, sg, rn);
      end
      send(d, i, sg, rn, e, 1);
    end
    drain();

    // Random backpressure
    bp_mode = 1;
    for (int i = 0; i < 200; i++) begin
      sh = $urandom_range(0, 15); sg = $urandom_range(0, 1); rn = $urandom_range(0, 1);
      for (int j = 0; j < NI; j++) begin
        d[j] = IW'($urandom);
        e[j] = model(d[j], sh, sg, rn);
      end
      send(d, sh, sg, rn, e, 0);
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    bp_mode = 0;

    // Reset while full and stalled
    bp_mode = 2;
    repeat (2) begin
      @(posedge clk); #1;
    end
    send(iv('{1, 2, 3, 4, 5, 6, 7, 8}), 0, 0, 0, iv('{1, 2, 3, 4, 5, 6, 7, 8}), 0);
    send(iv('{9, 10, 11, 12, 13, 14, 15, 16}), 0, 0, 0, iv('{9, 10, 11, 12, 13, 14, 15, 16}), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    cnt = 0;
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    chk_vec("midrst_out", out, z);
    rst = 1'b0;
    bp_mode = 0;
    @(posedge clk); #1;
    send(iv('{100, -100, 200, -200, 300, -300, 1, -1}), 2, 1, 1,
         iv('{25, -25, 50, -50, 75, -75, 0, 0}), 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
